// File: rtl/audio_pkg.sv
// audio_pkg: types and constants shared by the audio path (synthesizers,
// sample buffer, DAC serializer).
//   SAMPLE_W    : bits per channel word
//   CNT_W       : width of a counter that can hold 0..SAMPLE_W
//   sample_t    : signed two's complement channel word
//   ser_state_t : serializer framing state (SYNC until first left start)
package audio_pkg;

  localparam int SAMPLE_W = 24;
  localparam int CNT_W    = $clog2(SAMPLE_W + 1);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } ser_state_t;

  // Bit that goes on the wire next when shifting MSB first.
  function automatic logic sample_msb(input sample_t s);
    return s[SAMPLE_W-1];
  endfunction

endpackage

// File: rtl/pin_edge_sync.sv
// pin_edge_sync: brings an asynchronous pin into the clk domain through a
// SYNC_STAGES flop chain and flags its edges.
//   clk, rst_n : clock, synchronous active-low reset (clears the chain)
//   pin        : asynchronous input
//   level      : synchronized pin level
//   rise, fall : 1-clk pulses when the synchronized level changes
module pin_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus one extra flop holding the previous level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign fall  = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/i2s_dac_serializer.sv
// i2s_dac_serializer: pops one stereo sample per LRCK frame from a FWFT
// sample buffer and shifts it out MSB first in I2S format (one BCLK of delay
// after each LRCK edge). The codec is bus master; BCLK and DACLRCK are
// oversampled in the clk domain.
//   clk, rst_n        : clock, synchronous active-low reset
//   aud_bclk          : codec bit clock (async)
//   aud_daclrck       : codec DAC LR clock (async), 0 = left, 1 = right
//   fifo_empty        : sample buffer empty
//   fifo_data_l/_r    : sample at buffer head
//   fifo_rd_en        : 1-clk pop pulse
//   aud_dacdat        : serial data to codec
//   frame_start       : 1-clk pulse at each left-channel start
//   underflow         : 1-clk pulse when a frame starts with the buffer empty
//   underflow_count   : saturating underflow event count
module i2s_dac_serializer
  import audio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int UFLOW_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                aud_bclk,
  input  logic                aud_daclrck,
  input  logic                fifo_empty,
  input  logic [SAMPLE_W-1:0] fifo_data_l,
  input  logic [SAMPLE_W-1:0] fifo_data_r,
  output logic                fifo_rd_en,
  output logic                aud_dacdat,
  output logic                frame_start,
  output logic                underflow,
  output logic [UFLOW_W-1:0]  underflow_count
);

  logic bclk_level_s, bclk_rise_s, bclk_fall_s;
  logic lr_level_s, lr_rise_s, lr_fall_s;

  pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (aud_bclk),
    .level (bclk_level_s),
    .rise  (bclk_rise_s),
    .fall  (bclk_fall_s)
  );

  pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (aud_daclrck),
    .level (lr_level_s),
    .rise  (lr_rise_s),
    .fall  (lr_fall_s)
  );

  // LRCK is only meaningful at BCLK falls, so its own edge pulses are unused.
  logic unused_s;
  assign unused_s = &{1'b0, bclk_level_s, bclk_rise_s, lr_rise_s, lr_fall_s};

  ser_state_t         state_r, next_state_s;
  logic               lr_q_r;
  sample_t            shift_r;
  sample_t            right_hold_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic               dacdat_r;
  logic               rd_en_r;
  logic               frame_start_r;
  logic               underflow_r;
  logic [UFLOW_W-1:0] uflow_cnt_r;

  logic lr_edge_s, left_start_s, right_start_s;

  // Framing state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SYNC;
    end else begin
      state_r <= next_state_s;
    end
  end

  // LRCK edge classification and next-state decode.
  always_comb begin
    next_state_s  = state_r;
    lr_edge_s     = 1'b0;
    left_start_s  = 1'b0;
    right_start_s = 1'b0;
    if (bclk_fall_s && (lr_level_s != lr_q_r)) begin
      lr_edge_s = 1'b1;
    end else begin
      lr_edge_s = 1'b0;
    end
    case (state_r)
      SYNC: begin
        // Right-channel edges are ignored until the first left start aligns us.
        if (lr_edge_s && !lr_level_s) begin
          next_state_s = RUN;
          left_start_s = 1'b1;
        end else begin
          next_state_s = SYNC;
        end
      end
      RUN: begin
        next_state_s = RUN;
        if (lr_edge_s && !lr_level_s) begin
          left_start_s = 1'b1;
        end else if (lr_edge_s) begin
          right_start_s = 1'b1;
        end else begin
          left_start_s  = 1'b0;
          right_start_s = 1'b0;
        end
      end
      default: begin
        next_state_s = SYNC;
      end
    endcase
  end

  // Sample fetch, shift register, bit counter and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lr_q_r        <= 1'b0;
      shift_r       <= '0;
      right_hold_r  <= '0;
      bit_cnt_r     <= '0;
      dacdat_r      <= 1'b0;
      rd_en_r       <= 1'b0;
      frame_start_r <= 1'b0;
      underflow_r   <= 1'b0;
      uflow_cnt_r   <= '0;
    end else begin
      rd_en_r       <= 1'b0;
      frame_start_r <= 1'b0;
      underflow_r   <= 1'b0;
      if (bclk_fall_s) begin
        lr_q_r <= lr_level_s;
      end
      if (left_start_s) begin
        // Delay slot: the bit under this BCLK is always 0, MSB follows.
        frame_start_r <= 1'b1;
        dacdat_r      <= 1'b0;
        bit_cnt_r     <= CNT_W'(SAMPLE_W);
        if (!fifo_empty) begin
          rd_en_r      <= 1'b1;
          shift_r      <= sample_t'(fifo_data_l);
          right_hold_r <= sample_t'(fifo_data_r);
        end else begin
          shift_r      <= '0;
          right_hold_r <= '0;
          underflow_r  <= 1'b1;
          if (uflow_cnt_r != {UFLOW_W{1'b1}}) begin
            uflow_cnt_r <= uflow_cnt_r + UFLOW_W'(1);
          end
        end
      end else if (right_start_s) begin
        shift_r   <= right_hold_r;
        dacdat_r  <= 1'b0;
        bit_cnt_r <= CNT_W'(SAMPLE_W);
      end else if (bclk_fall_s && (state_r == RUN)) begin
        // After the word is exhausted the line carries pad zeros.
        if (bit_cnt_r != '0) begin
          dacdat_r  <= sample_msb(shift_r);
          shift_r   <= {shift_r[SAMPLE_W-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r - CNT_W'(1);
        end else begin
          dacdat_r <= 1'b0;
        end
      end
    end
  end

  assign fifo_rd_en      = rd_en_r;
  assign aud_dacdat      = dacdat_r;
  assign frame_start     = frame_start_r;
  assign underflow       = underflow_r;
  assign underflow_count = uflow_cnt_r;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
`timescale 1ns/100ps
// Bench for i2s_dac_serializer: a codec model drives BCLK/LRCK and decodes
// the serial stream on BCLK rise; a FIFO model feeds samples; a frame-level
// model predicts words, pops, underflows and the counter.
module tb_i2s_dac_serializer;
  import audio_pkg::*;

  localparam int  UW        = 16;
  localparam real BCLK_HALF = 162.8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                aud_bclk = 1'b1;
  logic                aud_daclrck = 1'b1;
  logic                fifo_empty = 1'b1;
  logic [SAMPLE_W-1:0] fifo_data_l = '0;
  logic [SAMPLE_W-1:0] fifo_data_r = '0;
  logic                fifo_rd_en, aud_dacdat, frame_start, underflow;
  logic [UW-1:0]       underflow_count;

  i2s_dac_serializer #(.SYNC_STAGES(2), .UFLOW_W(UW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .aud_bclk        (aud_bclk),
    .aud_daclrck     (aud_daclrck),
    .fifo_empty      (fifo_empty),
    .fifo_data_l     (fifo_data_l),
    .fifo_data_r     (fifo_data_r),
    .fifo_rd_en      (fifo_rd_en),
    .aud_dacdat      (aud_dacdat),
    .frame_start     (frame_start),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  typedef struct { logic [23:0] l; logic [23:0] r; } smp_t;
  smp_t fifo_q[$];

  task automatic fifo_refresh();
    if (fifo_q.size() == 0) begin
      fifo_empty = 1'b1; fifo_data_l = '0; fifo_data_r = '0;
    end else begin
      fifo_empty = 1'b0; fifo_data_l = fifo_q[0].l; fifo_data_r = fifo_q[0].r;
    end
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    smp_t s;
    s.l = l; s.r = r;
    fifo_q.push_back(s);
    fifo_refresh();
  endtask

  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      #1;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  // ---------------- frame-level model ----------------
  typedef struct { int id; logic [23:0] l; logic [23:0] r; } exp_t;
  exp_t exp_q[$];
  bit      armed = 1'b0;
  bit      run_m = 1'b0;
  int      fid = 0;
  logic [UW-1:0] cnt_m = '0;
  int exp_rd = 0, exp_uf = 0, exp_fs = 0;
  int seen_rd = 0, seen_uf = 0, seen_fs = 0;

  task automatic close_frame();
    check("pops per frame", seen_rd, exp_rd);
    check("underflow pulses per frame", seen_uf, exp_uf);
    check("frame_start pulses per frame", seen_fs, exp_fs);
    check("underflow_count", underflow_count, cnt_m);
    seen_rd = 0; seen_uf = 0; seen_fs = 0;
  endtask

  task automatic bclk_run(input logic lr, input int n);
    for (int i = 0; i < n; i++) begin
      aud_bclk = 1'b0; aud_daclrck = lr;
      #(BCLK_HALF);
      aud_bclk = 1'b1;
      #(BCLK_HALF);
    end
  endtask

  // One LRCK frame: left for left_n BCLKs, right for right_n BCLKs.
  task automatic frame(input int left_n, input int right_n);
    exp_t e;
    close_frame();
    fid++;
    if (armed) run_m = 1'b1;
    e.id = fid; e.l = '0; e.r = '0;
    exp_rd = 0; exp_uf = 0; exp_fs = 0;
    if (run_m) begin
      exp_fs = 1;
      if (fifo_q.size() > 0) begin
        e.l = fifo_q[0].l; e.r = fifo_q[0].r; exp_rd = 1;
      end else begin
        exp_uf = 1;
        if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      end
    end
    exp_q.push_back(e);
    bclk_run(1'b0, left_n);
    bclk_run(1'b1, right_n);
  endtask

  // ---------------- per-cycle output checks ----------------
  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      seen_rd++;
      check("pop while empty", fifo_empty, 1'b0);
    end
    if (underflow === 1'b1) seen_uf++;
    if (frame_start === 1'b1) seen_fs++;
    if (!run_m) check("silent while unsynced", {aud_dacdat, fifo_rd_en, underflow, frame_start}, 4'b0);
  end

  // ---------------- codec decoder (captures on BCLK rise) ----------------
  logic        lr_prev = 1'b1;
  int          idx = 0;
  int          dec_frame = 0;
  int          nbits = 0;
  logic [23:0] word = '0;
  bit          pad_bad = 1'b0;
  logic [23:0] dec_l[int];
  logic [23:0] dec_r[int];

  task automatic finalize(input logic is_left);
    logic [23:0] ew;
    while (exp_q.size() > 0 && exp_q[0].id < dec_frame) void'(exp_q.pop_front());
    if (is_left) dec_l[dec_frame] = word; else dec_r[dec_frame] = word;
    if (exp_q.size() > 0 && exp_q[0].id == dec_frame) begin
      ew = is_left ? exp_q[0].l : exp_q[0].r;
      ew = ew >> (24 - nbits);
      check(is_left ? "left word" : "right word", word, ew);
      check("delay slot and pad bits zero", pad_bad, 1'b0);
    end
  endtask

  always @(posedge aud_bclk) begin
    if (aud_daclrck !== lr_prev) begin
      finalize(!lr_prev);
      if (lr_prev == 1'b1) dec_frame++;
      lr_prev = aud_daclrck;
      idx = 0; word = '0; nbits = 0; pad_bad = 1'b0;
    end
    if (idx >= 1 && idx <= 24) begin
      word = {word[22:0], aud_dacdat};
      nbits++;
    end else if (aud_dacdat !== 1'b0) begin
      pad_bad = 1'b1;
    end
    idx++;
  end

  // ---------------- directed sequence ----------------
  initial begin
    #0.5;
    // Reset released while LRCK=1: must stay silent until the first LRCK fall.
    fork
      begin
        #(BCLK_HALF * 10);
        @(negedge clk); #1;
        rst_n = 1'b1; armed = 1'b1;
      end
    join_none
    bclk_run(1'b1, 20);
    check("no pop before first LRCK fall", seen_rd, 0);

    // Normal frames, including full-scale extremes.
    push(24'h800001, 24'h7FFFFE);
    push(24'h123456, 24'h654321);
    push(24'hFFFFFF, 24'h000001);
    frame(32, 32);
    frame(32, 32);
    frame(32, 32);
    check("frame1 left literal", dec_l[1], 24'h800001);
    check("frame1 right literal", dec_r[1], 24'h7FFFFE);

    // Three empty frames.
    frame(32, 32);
    frame(32, 32);
    frame(32, 32);
    check("underflow_count after 3 empties", underflow_count, 16'd3);
    check("empty frame left literal", dec_l[5], 24'h000000);

    // Counter preset near max then three more empty frames.
    fork
      begin
        #(BCLK_HALF * 20);
        @(negedge clk); #1;
        force dut.uflow_cnt_r = 16'hFFFE;
        @(negedge clk); #1;
        release dut.uflow_cnt_r;
        cnt_m = 16'hFFFE;
      end
    join_none
    frame(32, 32);
    frame(32, 32);
    frame(32, 32);
    frame(32, 32);
    check("underflow_count saturates", underflow_count, 16'hFFFF);

    // Short left channel: 1 delay slot + 10 data bits.
    push(24'hABCDEF, 24'h13579B);
    push(24'h0F0F0F, 24'hF0F0F0);
    frame(11, 53);
    frame(32, 32);
    check("short left literal", dec_l[11], 24'h0002AF);
    check("right after short left literal", dec_r[11], 24'h13579B);

    // Reset for one clk in the middle of a left word.
    push(24'h555555, 24'hAAAAAA);
    push(24'h3C3C3C, 24'hC3C3C3);
    fork
      begin
        #(BCLK_HALF * 16);
        @(negedge clk); #1;
        rst_n = 1'b0; run_m = 1'b0; cnt_m = '0; exp_q.delete();
        @(negedge clk);
        check("dacdat zero after reset", aud_dacdat, 1'b0);
        check("count cleared by reset", underflow_count, 16'd0);
        #1;
        rst_n = 1'b1;
      end
    join_none
    frame(32, 32);
    frame(32, 32);
    frame(32, 32);
    close_frame();
    check("resync left literal", dec_l[14], 24'h3C3C3C);
    check("resync right literal", dec_r[14], 24'hC3C3C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
